// File: rtl/melody_sequencer.sv
// Song-ROM sequencer driving the buzzer tone generator: beat timing,
// inter-note gap, pause freeze, abort and end-of-song done pulse.
module melody_sequencer #(
    parameter int BEAT_CYC = 12_500_000,
    parameter int GAP_CYC  = 1_000_000,
    parameter int SONG_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    output logic [14:0] tone,
    output logic        check,
    output logic        stop,
    output logic [4:0]  note_idx,
    output logic        busy,
    output logic        done
);

    localparam int PLAY_MAX = 15 * BEAT_CYC;
    localparam int CNT_MAX  = (GAP_CYC > PLAY_MAX) ? GAP_CYC : PLAY_MAX;
    localparam int CW       = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] BEAT_W   = CW'(BEAT_CYC);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [4:0]    LAST_IDX = 5'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [4:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [14:0]   r_tone;
    logic          r_check;
    logic          r_stop;
    logic          r_busy;
    logic          r_done;

    state_t        w_nxt_state;
    logic [4:0]    w_nxt_idx;
    logic [CW-1:0] w_nxt_cnt;
    logic [14:0]   w_nxt_tone;
    logic          w_nxt_done;
    logic          w_nxt_check;
    logic          w_nxt_stop;
    logic          w_nxt_busy;

    logic [7:0]    w_entry;
    logic [7:0]    w_first;
    logic [7:0]    w_next;
    logic [4:0]    w_nidx;
    logic [CW-1:0] w_play_last;
    logic          w_play_end;
    logic          w_gap_end;
    logic          w_frz;
    logic          w_adv;
    logic          w_fin;

    // Entry = {pitch, dur}; dur of zero marks the end of the song.
    function automatic logic [7:0] rom(input logic [4:0] a);
        case (a)
            5'd0:    rom = 8'h11;
            5'd1:    rom = 8'h21;
            5'd2:    rom = 8'h31;
            5'd3:    rom = 8'h41;
            5'd4:    rom = 8'h51;
            5'd5:    rom = 8'h61;
            5'd6:    rom = 8'h71;
            5'd7:    rom = 8'h81;
            default: rom = 8'h00;
        endcase
    endfunction

    function automatic logic [14:0] pitch_tone(input logic [3:0] p);
        case (p)
            4'd1:    pitch_tone = 15'd7962;
            4'd2:    pitch_tone = 15'd7094;
            4'd3:    pitch_tone = 15'd6319;
            4'd4:    pitch_tone = 15'd5965;
            4'd5:    pitch_tone = 15'd5314;
            4'd6:    pitch_tone = 15'd4734;
            4'd7:    pitch_tone = 15'd4217;
            4'd8:    pitch_tone = 15'd3981;
            4'd9:    pitch_tone = 15'd3546;
            4'd10:   pitch_tone = 15'd3159;
            4'd11:   pitch_tone = 15'd2982;
            4'd12:   pitch_tone = 15'd2656;
            4'd13:   pitch_tone = 15'd2366;
            4'd14:   pitch_tone = 15'd2108;
            default: pitch_tone = 15'd0;
        endcase
    endfunction

    assign w_entry     = rom(r_idx);
    assign w_first     = rom(5'd0);
    assign w_nidx      = r_idx + 5'd1;
    assign w_next      = rom(w_nidx);
    assign w_play_last = CW'(w_entry[3:0]) * BEAT_W - CW'(1);
    assign w_play_end  = (r_cnt == w_play_last);
    assign w_gap_end   = (r_cnt == GAP_LAST);
    assign w_frz       = pause && (r_state != S_IDLE);
    assign w_fin       = (r_idx == LAST_IDX) || (w_next[3:0] == 4'd0);

    assign w_adv = !abort && !w_frz &&
                   (((r_state == S_PLAY) && w_play_end && (GAP_CYC == 0)) ||
                    ((r_state == S_GAP) && w_gap_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_tone  <= '0;
            r_check <= 1'b0;
            r_stop  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_tone  <= w_nxt_tone;
            r_check <= w_nxt_check;
            r_stop  <= w_nxt_stop;
            r_busy  <= w_nxt_busy;
            r_done  <= w_nxt_done;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        w_nxt_tone  = r_tone;
        w_nxt_done  = 1'b0;
        if (abort) begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = '0;
        end else if (!w_frz) begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_nxt_state = S_PLAY;
                        w_nxt_idx   = '0;
                        w_nxt_cnt   = '0;
                        w_nxt_tone  = pitch_tone(w_first[7:4]);
                    end
                end
                S_PLAY: begin
                    w_nxt_cnt = r_cnt + 1'b1;
                    if (w_play_end) begin
                        w_nxt_state = S_GAP;
                        w_nxt_cnt   = '0;
                    end
                end
                S_GAP: begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_cnt   = '0;
                end
            endcase
            // Advancing overrides the PLAY->GAP step when there is no gap.
            if (w_adv) begin
                w_nxt_cnt = '0;
                if (w_fin) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_done  = 1'b1;
                end else begin
                    w_nxt_state = S_PLAY;
                    w_nxt_idx   = w_nidx;
                    w_nxt_tone  = pitch_tone(w_next[7:4]);
                end
            end
        end
    end

    always_comb begin
        w_nxt_busy  = (w_nxt_state != S_IDLE);
        w_nxt_stop  = (w_nxt_state == S_IDLE) || w_frz;
        w_nxt_check = (w_nxt_state == S_PLAY) && !w_frz &&
                      (w_nxt_tone != 15'd0);
    end

    assign tone     = r_tone;
    assign check    = r_check;
    assign stop     = r_stop;
    assign note_idx = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: gapped and gapless instances, scoreboard
// of expected outputs keyed by cycle, plus pause/abort/reset sequences.
`timescale 1ns/1ps
module tb_melody_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_a;
    logic        start_b;
    logic        pause;
    logic        abort;
    logic [14:0] a_tone, b_tone;
    logic        a_check, b_check;
    logic        a_stop, b_stop;
    logic [4:0]  a_idx, b_idx;
    logic        a_busy, b_busy;
    logic        a_done, b_done;

    melody_sequencer #(.BEAT_CYC(10), .GAP_CYC(2), .SONG_LEN(32)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pause(pause),
        .abort(abort), .tone(a_tone), .check(a_check), .stop(a_stop),
        .note_idx(a_idx), .busy(a_busy), .done(a_done)
    );

    melody_sequencer #(.BEAT_CYC(10), .GAP_CYC(0), .SONG_LEN(32)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pause(pause),
        .abort(abort), .tone(b_tone), .check(b_check), .stop(b_stop),
        .note_idx(b_idx), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       nm;
        bit          sel;
        bit          tc;
        bit          ic;
        logic [14:0] tone;
        logic        check;
        logic        stop;
        logic        busy;
        logic        done;
        logic [4:0]  idx;
    } exp_t;

    typedef struct {
        logic [4:0]  idx;
        logic [14:0] tone;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   s0 = 0;

    task automatic cmp(input string nm, input bit sel, input bit tc,
                       input bit ic, input logic [14:0] et,
                       input logic ec, input logic es, input logic eb,
                       input logic ed, input logic [4:0] ei);
        logic [14:0] at;
        logic        ac, as, ab, ad;
        logic [4:0]  ai;
        at = sel ? b_tone  : a_tone;
        ac = sel ? b_check : a_check;
        as = sel ? b_stop  : a_stop;
        ab = sel ? b_busy  : a_busy;
        ad = sel ? b_done  : a_done;
        ai = sel ? b_idx   : a_idx;
        n_cmp++;
        if ((tc && at !== et) || (ic && ai !== ei) || ac !== ec ||
            as !== es || ab !== eb || ad !== ed) begin
            n_bad++;
            $display("FAIL %s @%0d: got tone=%0d chk=%b stop=%b busy=%b done=%b idx=%0d; want tone=%0d chk=%b stop=%b busy=%b done=%b idx=%0d",
                     nm, cyc, at, ac, as, ab, ad, ai, et, ec, es, eb, ed, ei);
        end
    endtask

    task automatic exp_at(input int lbl, input string nm, input bit sel,
                          input bit tc, input bit ic, input logic [14:0] t,
                          input logic c, input logic s, input logic b,
                          input logic d, input logic [4:0] ix);
        exp_t e;
        e.cyc = s0 + lbl - 1;
        e.nm = nm;
        e.sel = sel;
        e.tc = tc;
        e.ic = ic;
        e.tone = t;
        e.check = c;
        e.stop = s;
        e.busy = b;
        e.done = d;
        e.idx = ix;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            if (q[0].cyc > cyc) break;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: sample slot %0d missed at %0d",
                         e.nm, e.cyc, cyc);
            end else begin
                cmp(e.nm, e.sel, e.tc, e.ic, e.tone, e.check, e.stop,
                    e.busy, e.done, e.idx);
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() > 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    vec_t song[8];

    initial begin
        song[0] = '{5'd0, 15'd7962};
        song[1] = '{5'd1, 15'd7094};
        song[2] = '{5'd2, 15'd6319};
        song[3] = '{5'd3, 15'd5965};
        song[4] = '{5'd4, 15'd5314};
        song[5] = '{5'd5, 15'd4734};
        song[6] = '{5'd6, 15'd4217};
        song[7] = '{5'd7, 15'd3981};

        rst_n = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("reset_a", 1'b0, 1, 1, 15'd0, 0, 1, 0, 0, 5'd0);
        cmp("reset_b", 1'b1, 1, 1, 15'd0, 0, 1, 0, 0, 5'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full gapped song.
        start_a = 1'b1;
        s0 = cyc + 1;
        for (int k = 0; k < 8; k++) begin
            exp_at(1 + 12 * k, $sformatf("a_note%0d_on", k), 0, 1, 1,
                   song[k].tone, 1, 0, 1, 0, song[k].idx);
            exp_at(10 + 12 * k, $sformatf("a_note%0d_end", k), 0, 1, 1,
                   song[k].tone, 1, 0, 1, 0, song[k].idx);
            exp_at(11 + 12 * k, $sformatf("a_gap%0d", k), 0, 1, 1,
                   song[k].tone, 0, 0, 1, 0, song[k].idx);
        end
        exp_at(97, "a_done", 0, 0, 1, 15'd0, 0, 1, 0, 1, 5'd7);
        exp_at(98, "a_after_done", 0, 0, 1, 15'd0, 0, 1, 0, 0, 5'd7);
        @(negedge clk);
        start_a = 1'b0;
        drain(120);

        // Pause for 5 cycles, then abort mid-song.
        start_a = 1'b1;
        s0 = cyc + 1;
        exp_at(1, "p_on", 0, 1, 1, 15'd7962, 1, 0, 1, 0, 5'd0);
        exp_at(5, "p_mute_first", 0, 1, 1, 15'd7962, 0, 1, 1, 0, 5'd0);
        exp_at(9, "p_mute_last", 0, 1, 1, 15'd7962, 0, 1, 1, 0, 5'd0);
        exp_at(10, "p_resume", 0, 1, 1, 15'd7962, 1, 0, 1, 0, 5'd0);
        exp_at(17, "p_gap", 0, 1, 1, 15'd7962, 0, 0, 1, 0, 5'd0);
        exp_at(18, "p_note1", 0, 1, 1, 15'd7094, 1, 0, 1, 0, 5'd1);
        exp_at(31, "abort_idle", 0, 0, 0, 15'd0, 0, 1, 0, 0, 5'd0);
        exp_at(32, "abort_nodone", 0, 0, 0, 15'd0, 0, 1, 0, 0, 5'd0);
        exp_at(40, "abort_stays", 0, 0, 0, 15'd0, 0, 1, 0, 0, 5'd0);
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(s0 + 3);
        pause = 1'b1;
        wait_cyc(s0 + 8);
        pause = 1'b0;
        wait_cyc(s0 + 29);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain(60);

        // Restart after abort, with a redundant start mid-note.
        start_a = 1'b1;
        s0 = cyc + 1;
        exp_at(1, "r_on", 0, 1, 1, 15'd7962, 1, 0, 1, 0, 5'd0);
        exp_at(7, "r_ignore", 0, 1, 1, 15'd7962, 1, 0, 1, 0, 5'd0);
        exp_at(12, "r_gap", 0, 1, 1, 15'd7962, 0, 0, 1, 0, 5'd0);
        exp_at(13, "r_note1", 0, 1, 1, 15'd7094, 1, 0, 1, 0, 5'd1);
        exp_at(15, "r_abort", 0, 0, 0, 15'd0, 0, 1, 0, 0, 5'd0);
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(s0 + 4);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(s0 + 13);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain(40);

        // Start and abort together from IDLE.
        start_a = 1'b1;
        abort = 1'b1;
        s0 = cyc + 1;
        exp_at(1, "sa_idle", 0, 0, 0, 15'd0, 0, 1, 0, 0, 5'd0);
        exp_at(3, "sa_idle2", 0, 0, 0, 15'd0, 0, 1, 0, 0, 5'd0);
        @(negedge clk);
        start_a = 1'b0;
        abort = 1'b0;
        drain(20);

        // Asynchronous reset in the gap.
        start_a = 1'b1;
        s0 = cyc + 1;
        exp_at(1, "g_on", 0, 1, 1, 15'd7962, 1, 0, 1, 0, 5'd0);
        exp_at(11, "g_gap", 0, 1, 1, 15'd7962, 0, 0, 1, 0, 5'd0);
        @(negedge clk);
        start_a = 1'b0;
        wait_cyc(s0 + 10);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst_mid_gap", 1'b0, 1, 1, 15'd0, 0, 1, 0, 0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        s0 = cyc + 1;
        exp_at(1, "rr_on", 0, 1, 1, 15'd7962, 1, 0, 1, 0, 5'd0);
        exp_at(12, "rr_gap", 0, 1, 1, 15'd7962, 0, 0, 1, 0, 5'd0);
        exp_at(13, "rr_note1", 0, 1, 1, 15'd7094, 1, 0, 1, 0, 5'd1);
        @(negedge clk);
        start_a = 1'b0;
        drain(40);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        // Gapless instance.
        start_b = 1'b1;
        s0 = cyc + 1;
        for (int k = 0; k < 8; k++) begin
            exp_at(1 + 10 * k, $sformatf("b_note%0d_on", k), 1, 1, 1,
                   song[k].tone, 1, 0, 1, 0, song[k].idx);
            exp_at(10 + 10 * k, $sformatf("b_note%0d_end", k), 1, 1, 1,
                   song[k].tone, 1, 0, 1, 0, song[k].idx);
        end
        exp_at(81, "b_done", 1, 0, 1, 15'd0, 0, 1, 0, 1, 5'd7);
        exp_at(82, "b_after_done", 1, 0, 1, 15'd0, 0, 1, 0, 0, 5'd7);
        @(negedge clk);
        start_b = 1'b0;
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream driver of the buzzer square-wave generator.
- Steps through a fixed internal song ROM of {pitch code, duration} entries and turns each pitch code into a 15-bit half-period count.
- Drives the generator's tone, enable (check) and mute (stop) inputs, with beat timing and an inter-note gap.
- Controlled by one start pulse, a pause level and an abort pulse from the button/control logic.

Parameters:
- BEAT_CYC, 12_500_000: clk cycles per duration unit (beat); must be ≥1.
- GAP_CYC, 1_000_000: silent clk cycles after every note; 0 means no gap.
- SONG_LEN, 32: ROM depth; must be ≤32.

Ports:
- clk  input  1  system clock (50 MHz).
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins playback from entry 0.
- pause  input  1  level; freezes playback and mutes.
- abort  input  1  one-cycle pulse; ends playback immediately.
- tone  output  15  half-period count for the downstream generator (its toneIn).
- check  output  1  tone-valid enable to the generator.
- stop  output  1  mute to the generator.
- note_idx  output  5  current ROM entry index.
- busy  output  1  high in PLAY/GAP.
- done  output  1  one-cycle pulse at natural end of song.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values, applied immediately on rst_n low, including mid-note: tone=0, check=0, stop=1, note_idx=0, busy=0, done=0, state=IDLE, counters=0.
- ROM entry format: 8 bits, pitch[7:4], dur[3:0]. dur=0 is the end-of-song marker.
- ROM contents: entries 0..7 = pitch 1..7 then 8, each with dur=1 (ascending C4..C5 scale); entry 8 = 0x00; remaining entries = 0x00.
- Pitch table (code→tone):
  - 0 or 15: rest, tone 0.
  - 1: 7962, 2: 7094, 3: 6319, 4: 5965, 5: 5314, 6: 4734, 7: 4217.
  - 8: 3981, 9: 3546, 10: 3159, 11: 2982, 12: 2656, 13: 2366, 14: 2108.
- States: IDLE, PLAY, GAP.
- IDLE: stop=1, check=0. Start sampled high at edge N → at N+1: state=PLAY, note_idx=0, tone=table(entry0.pitch), check=1 (0 if rest), stop=0, busy=1.
- PLAY: lasts exactly dur*BEAT_CYC cycles; the counter is sized for 15*BEAT_CYC with no overflow. Then:
  - GAP when GAP_CYC>0: check=0, stop=0, tone held, for GAP_CYC cycles.
  - Otherwise direct to next entry.
- Advance: note_idx+1. If the new entry has dur=0, or the old index was SONG_LEN-1:
  - state=IDLE, done=1 for one cycle, busy=0, stop=1, check=0, note_idx held at last played index.
  - Else PLAY with the new tone; consecutive entries play back-to-back with no idle cycle.
- Rest entries: PLAY timing unchanged, check=0, stop=0.
- Pause=1 during PLAY/GAP: all counters and state freeze; stop=1, check forced 0. On release, timing resumes from the frozen count. Pause in IDLE has no effect.
- Abort: from any state → IDLE at next edge; stop=1, check=0, busy=0, done stays 0.
- Start while busy: ignored.
- Start and abort in the same cycle: abort wins.
- Start in the same cycle as a done pulse: a new song begins at the next edge.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Run parameters BEAT_CYC=10, GAP_CYC=2. Start pulse at edge N.
  → At N+1: tone=7962, check=1, stop=0, busy=1.
  → At N+11: check=0 for 2 cycles.
  → At N+13: tone=7094.
  → Note k begins at N+1+12k.
  → done pulses at N+97; then stop=1 and busy=0.
- Pause held 5 cycles starting at N+4.
  → stop=1 and check=0 during the pause.
  → Note 1 begins at N+18 instead of N+13.
- Abort at N+30.
  → At N+31: stop=1, check=0, busy=0.
  → No done pulse.
  → A subsequent start restarts at tone=7962.
- Start re-pulsed during PLAY → no change to note_idx or timing. Start and abort in the same cycle from IDLE → remains IDLE.
- rst_n asserted mid-GAP → outputs take reset values without waiting for a clock edge. Release rst_n, then start → normal playback from entry 0.
- GAP_CYC=0 → notes are back-to-back; note k begins at N+1+10k; done pulses at N+81.
